// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: shift-mode codes,
// burst FSM state encoding and shift-direction helpers.
package usr_pkg;

  localparam logic [2:0] USR_SHL = 3'b000;
  localparam logic [2:0] USR_SHR = 3'b001;
  localparam logic [2:0] USR_ROL = 3'b010;
  localparam logic [2:0] USR_ROR = 3'b011;
  localparam logic [2:0] USR_ASR = 3'b100;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Modes 101..111 move nothing, so they count as neither direction
  function automatic logic shifts_left(input logic [2:0] m);
    return (m == USR_SHL) || (m == USR_ROL);
  endfunction

  function automatic logic shifts_right(input logic [2:0] m);
    return (m == USR_SHR) || (m == USR_ROR) || (m == USR_ASR);
  endfunction

endpackage

// File: rtl/usr_burst_ctrl.sv
// Burst controller for univ_shift_reg: IDLE/RUN/DONE FSM with the
// remaining-shift counter and the mode latched at burst start.
module usr_burst_ctrl
  import usr_pkg::*;
#(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          sync_rst,
  input  logic          load,
  input  logic          start,
  input  logic [CW-1:0] cnt,
  input  logic [2:0]    mode,
  output logic          busy,
  output logic          done,
  output logic          step,
  output logic [2:0]    run_mode
);

  logic [1:0]    state;
  logic [CW-1:0] remaining;

  // load aborts any burst without producing a done pulse
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      state     <= ST_IDLE;
      remaining <= '0;
      run_mode  <= USR_SHL;
    end else if (load) begin
      state     <= ST_IDLE;
      remaining <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            run_mode <= mode;
            if (cnt == '0) begin
              state <= ST_DONE;
            end else begin
              state     <= ST_RUN;
              remaining <= cnt;
            end
          end
        end
        ST_RUN: begin
          remaining <= remaining - CW'(1);
          if (remaining == CW'(1)) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);
  assign step = (state == ST_RUN);

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register with parallel load, single steps and counted bursts.
// Optional feature: define USR_SO_CAPTURE_EN to add the so_acc shifted-out collector.
module univ_shift_reg
  import usr_pkg::*;
#(
  parameter  int DW = 8,
  localparam int CW = $clog2(DW + 1)
) (
  input  logic          clk,
  input  logic          sync_rst,
  input  logic          load,
  input  logic [DW-1:0] data,
  input  logic          en,
  input  logic [2:0]    mode,
  input  logic          data_l,
  input  logic          data_r,
  input  logic          start,
  input  logic [CW-1:0] cnt,
  output logic [DW-1:0] q,
`ifdef USR_SO_CAPTURE_EN
  output logic [DW-1:0] so_acc,
`endif
  output logic          so_l,
  output logic          so_r,
  output logic          busy,
  output logic          done
);

  logic       burst_step;
  logic [2:0] run_mode;
  logic       do_step;
  logic [2:0] step_mode;

  function automatic logic [DW-1:0] shift_once(input logic [DW-1:0] v, input logic [2:0] m,
                                               input logic fill_l, input logic fill_r);
    case (m)
      USR_SHL: return {v[DW-2:0], fill_l};
      USR_SHR: return {fill_r, v[DW-1:1]};
      USR_ROL: return {v[DW-2:0], v[DW-1]};
      USR_ROR: return {v[0], v[DW-1:1]};
      USR_ASR: return {v[DW-1], v[DW-1:1]};
      default: return v;
    endcase
  endfunction

  usr_burst_ctrl #(.CW(CW)) u_ctrl (
    .clk      (clk),
    .sync_rst (sync_rst),
    .load     (load),
    .start    (start),
    .cnt      (cnt),
    .mode     (mode),
    .busy     (busy),
    .done     (done),
    .step     (burst_step),
    .run_mode (run_mode)
  );

  // A running burst owns the datapath; live en/mode only matter outside RUN
  always_comb begin
    do_step   = burst_step | en;
    step_mode = burst_step ? run_mode : mode;
  end

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      q <= '0;
    end else if (load) begin
      q <= data;
    end else if (do_step) begin
      q <= shift_once(q, step_mode, data_l, data_r);
    end
  end

`ifdef USR_SO_CAPTURE_EN
  always_ff @(posedge clk) begin
    if (sync_rst || load) begin
      so_acc <= '0;
    end else if (do_step && shifts_left(step_mode)) begin
      so_acc <= {so_acc[DW-2:0], q[DW-1]};
    end else if (do_step && shifts_right(step_mode)) begin
      so_acc <= {q[0], so_acc[DW-1:1]};
    end
  end
`endif

  assign so_l = q[DW-1];
  assign so_r = q[0];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg (DW=8): directed scenarios plus random
// traffic against a queue-of-pending-shifts reference model.
module tb_univ_shift_reg;
  localparam int DW = 8;
  localparam int CW = $clog2(DW + 1);

  logic          clk = 1'b0;
  logic          sync_rst, load, en, data_l, data_r, start;
  logic [DW-1:0] data;
  logic [2:0]    mode;
  logic [CW-1:0] cnt;
  logic [DW-1:0] q;
  logic          so_l, so_r, busy, done;
`ifdef USR_SO_CAPTURE_EN
  logic [DW-1:0] so_acc;
`endif

  int         n_cmp = 0;
  int         n_err = 0;
  int         mq    = 0;
  int         macc  = 0;
  bit         mdone = 1'b0;
  logic [2:0] ops[$];

  univ_shift_reg #(.DW(DW)) dut (
    .clk      (clk),
    .sync_rst (sync_rst),
    .load     (load),
    .data     (data),
    .en       (en),
    .mode     (mode),
    .data_l   (data_l),
    .data_r   (data_r),
    .start    (start),
    .cnt      (cnt),
    .q        (q),
`ifdef USR_SO_CAPTURE_EN
    .so_acc   (so_acc),
`endif
    .so_l     (so_l),
    .so_r     (so_r),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One shift of an 8-bit value, written as plain arithmetic
  function automatic int shModel(int v, logic [2:0] m, logic fl, logic fr);
    case (m)
      3'd0:    return (v * 2) % 256 + int'(fl);
      3'd1:    return v / 2 + int'(fr) * 128;
      3'd2:    return (v * 2) % 256 + v / 128;
      3'd3:    return v / 2 + (v % 2) * 128;
      3'd4:    return v / 2 + (v / 128) * 128;
      default: return v;
    endcase
  endfunction

  task automatic modelShift(input logic [2:0] m);
    if (m == 3'd0 || m == 3'd2) macc = (macc * 2) % 256 + mq / 128;
    else if (m == 3'd1 || m == 3'd3 || m == 3'd4) macc = macc / 2 + (mq % 2) * 128;
    mq = shModel(mq, m, data_l, data_r);
  endtask

  // Reference: an accepted burst becomes a queue of cnt pending shifts
  task automatic modelEdge();
    bit nd;
    if (sync_rst) begin
      mq = 0; macc = 0; mdone = 1'b0; ops.delete();
    end else if (load) begin
      mq = int'(data); macc = 0; mdone = 1'b0; ops.delete();
    end else if (ops.size() > 0) begin
      modelShift(ops.pop_front());
      mdone = (ops.size() == 0);
    end else begin
      nd = 1'b0;
      if (!mdone && start) begin
        if (cnt == 0) nd = 1'b1;
        else for (int i = 0; i < int'(cnt); i++) ops.push_back(mode);
      end
      if (en) modelShift(mode);
      mdone = nd;
    end
  endtask

  task automatic applyStimulus(input logic r, input logic ld, input logic [7:0] d, input logic e,
                               input logic [2:0] m, input logic dl, input logic dr,
                               input logic st, input logic [CW-1:0] c);
    sync_rst = r; load = ld; data = d; en = e; mode = m;
    data_l = dl; data_r = dr; start = st; cnt = c;
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput("q", 32'(q), 32'(mq));
    checkOutput("so_l", 32'(so_l), 32'(mq / 128));
    checkOutput("so_r", 32'(so_r), 32'(mq % 2));
    checkOutput("busy", 32'(busy), 32'(ops.size() > 0));
    checkOutput("done", 32'(done), 32'(mdone));
`ifdef USR_SO_CAPTURE_EN
    checkOutput("so_acc", 32'(so_acc), 32'(macc));
`endif
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 8'h00, 0, 3'd0, 0, 0, 0, '0);
  endtask

  initial begin
    applyStimulus(1, 0, 8'h00, 0, 3'd0, 0, 0, 0, '0);
    applyStimulus(1, 0, 8'h00, 0, 3'd0, 0, 0, 0, '0);
    checkOutput("reset_q", 32'(q), 32'h0);

    applyStimulus(0, 1, 8'hA5, 0, 3'd0, 0, 0, 0, '0);
    applyStimulus(0, 0, 8'h00, 1, 3'd0, 1, 0, 0, '0);
    checkOutput("shl_step", 32'(q), 32'h4B);
    applyStimulus(0, 0, 8'h00, 1, 3'd4, 0, 0, 0, '0);
    checkOutput("asr_step", 32'(q), 32'h25);

    applyStimulus(0, 1, 8'h81, 0, 3'd0, 0, 0, 0, '0);
    applyStimulus(0, 0, 8'h00, 0, 3'd2, 0, 0, 1, 4'd3);
    idleCycles(3);
    checkOutput("rol3_q", 32'(q), 32'h0C);
    checkOutput("rol3_done", 32'(done), 32'h1);
    idleCycles(1);

    applyStimulus(0, 0, 8'h00, 0, 3'd1, 0, 0, 1, 4'd0);
    checkOutput("cnt0_done", 32'(done), 32'h1);
    checkOutput("cnt0_q", 32'(q), 32'h0C);
    idleCycles(1);

    applyStimulus(0, 1, 8'hF0, 0, 3'd0, 0, 0, 0, '0);
    applyStimulus(0, 0, 8'h00, 0, 3'd1, 0, 0, 1, 4'd4);
    applyStimulus(0, 0, 8'h00, 0, 3'd0, 0, 0, 1, 4'd2);
    applyStimulus(0, 1, 8'h3C, 0, 3'd0, 0, 0, 0, '0);
    checkOutput("abort_q", 32'(q), 32'h3C);
    idleCycles(4);

    applyStimulus(0, 1, 8'h55, 0, 3'd0, 0, 0, 0, '0);
    applyStimulus(0, 0, 8'h00, 0, 3'd0, 1, 0, 1, 4'd5);
    idleCycles(2);
    applyStimulus(1, 0, 8'h00, 0, 3'd0, 0, 0, 0, '0);
    checkOutput("midrst_q", 32'(q), 32'h0);
    idleCycles(5);

`ifdef USR_SO_CAPTURE_EN
    applyStimulus(0, 1, 8'hC3, 0, 3'd0, 0, 0, 0, '0);
    applyStimulus(0, 0, 8'h00, 0, 3'd0, 0, 0, 1, 4'd8);
    idleCycles(8);
    checkOutput("cap_acc", 32'(so_acc), 32'hC3);
    checkOutput("cap_q", 32'(q), 32'h0);
    applyStimulus(0, 1, 8'h12, 0, 3'd0, 0, 0, 0, '0);
    checkOutput("cap_clear", 32'(so_acc), 32'h0);
`endif

    for (int i = 0; i < 800; i++) begin
      applyStimulus(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 7),
                    8'($urandom), ($urandom_range(0, 99) < 40), 3'($urandom_range(0, 7)),
                    1'($urandom), 1'($urandom), ($urandom_range(0, 99) < 20),
                    CW'($urandom_range(0, 11)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
